// File: rtl/external_bus_controller_pkg.sv
// external_bus_controller_pkg: shared state encoding and constants for the external bus controller.
package external_bus_controller_pkg;
    typedef enum logic [1:0] {BUS_IDLE, BUS_REQ, BUS_DONE} bus_state_t;
    localparam logic [7:0] BUS_ERR_DATA = 8'hEA;
endpackage

// File: rtl/external_bus_controller_watchdog.sv
// bus_watchdog: counts REQ cycles and flags the last cycle a transaction may wait for mem_ack.
module bus_watchdog #(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic clk,
    input  logic nrst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);
    logic [7:0] r_count;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) r_count <= 8'd0;
        else if (i_clear) r_count <= 8'd0;
        else if (i_enable) r_count <= r_count + 8'd1;
    end

    assign o_expire = i_enable && (r_count == 8'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/external_bus_controller.sv
// external_bus_controller: turns CPU bus cycles into req/ack memory transactions, stalling the CPU until done.
module external_bus_controller
    import external_bus_controller_pkg::*;
#(
    parameter int         TIMEOUT_CYC = 15,
    parameter logic [7:0] ERR_DATA    = BUS_ERR_DATA
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        cpu_access,
    input  logic        cpu_write,
    input  logic [7:0]  cpu_addr_low,
    input  logic [7:0]  cpu_addr_high,
    input  logic [7:0]  cpu_data_out,
    output logic [7:0]  cpu_data_in,
    output logic        cpu_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        bus_timeout,
    input  logic        timeout_clear
);
    bus_state_t r_state;
    logic       w_wd_clear;
    logic       w_wd_en;
    logic       w_wd_expire;

    assign w_wd_clear = (r_state == BUS_IDLE) && cpu_access;
    assign w_wd_en    = (r_state == BUS_REQ);
    assign cpu_ready  = ((r_state == BUS_IDLE) && !cpu_access) || (r_state == BUS_DONE);

    bus_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wd (
        .clk      (clk),
        .nrst     (nrst),
        .i_clear  (w_wd_clear),
        .i_enable (w_wd_en),
        .o_expire (w_wd_expire)
    );

    // Clear is applied before the REQ branch so a coincident timeout leaves the flag set.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= BUS_IDLE;
            cpu_data_in <= 8'h00;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 16'h0000;
            mem_wdata   <= 8'h00;
            bus_timeout <= 1'b0;
        end else begin
            if (timeout_clear) bus_timeout <= 1'b0;
            case (r_state)
                BUS_IDLE: if (cpu_access) begin
                    mem_addr  <= {cpu_addr_high, cpu_addr_low};
                    mem_wdata <= cpu_data_out;
                    mem_we    <= cpu_write;
                    mem_req   <= 1'b1;
                    r_state   <= BUS_REQ;
                end
                BUS_REQ: if (mem_ack) begin
                    if (!mem_we) cpu_data_in <= mem_rdata;
                    mem_req <= 1'b0;
                    r_state <= BUS_DONE;
                end else if (w_wd_expire) begin
                    if (!mem_we) cpu_data_in <= ERR_DATA;
                    bus_timeout <= 1'b1;
                    mem_req     <= 1'b0;
                    r_state     <= BUS_DONE;
                end
                BUS_DONE: r_state <= BUS_IDLE;
                default:  r_state <= BUS_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_external_bus_controller.sv
// tb_external_bus_controller: scoreboard bench driving CPU bus cycles against a scripted memory responder.
module tb_external_bus_controller;
    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        cpu_access = 1'b0;
    logic        cpu_write = 1'b0;
    logic [7:0]  cpu_addr_low = 8'h00;
    logic [7:0]  cpu_addr_high = 8'h00;
    logic [7:0]  cpu_data_out = 8'h00;
    logic [7:0]  cpu_data_in;
    logic        cpu_ready;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;
    logic        bus_timeout;
    logic        timeout_clear = 1'b0;

    typedef struct { logic [7:0] data; logic to; } exp_t;
    exp_t sb[$];
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic [7:0] m_data = 8'h00;
    logic       m_to = 1'b0;
    int d1, d2, d3;

    external_bus_controller dut (
        .clk(clk), .nrst(nrst), .cpu_access(cpu_access), .cpu_write(cpu_write),
        .cpu_addr_low(cpu_addr_low), .cpu_addr_high(cpu_addr_high), .cpu_data_out(cpu_data_out),
        .cpu_data_in(cpu_data_in), .cpu_ready(cpu_ready), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .bus_timeout(bus_timeout), .timeout_clear(timeout_clear)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ack_at: REQ cycle index carrying mem_ack (>=15 means never); clr_at: REQ cycle pulsing timeout_clear
    task automatic run_txn(input logic we, input logic [15:0] a, input logic [7:0] wd, input int ack_at,
                           input logic [7:0] rd, input logic hold, input int clr_at, output int done_cyc);
        int n, t0, exp_len;
        exp_t e;
        exp_len = (ack_at < 15) ? ack_at + 1 : 15;
        if (!we) m_data = (ack_at < 15) ? rd : 8'hEA;
        if (clr_at >= 0 && clr_at < exp_len) m_to = 1'b0;
        if (ack_at >= 15) m_to = 1'b1;
        e.data = m_data;
        e.to = m_to;
        sb.push_back(e);
        cpu_access = 1'b1;
        cpu_write = we;
        cpu_addr_high = a[15:8];
        cpu_addr_low = a[7:0];
        cpu_data_out = wd;
        t0 = cyc;
        #1 check("stall", {31'd0, cpu_ready}, 0);
        @(posedge clk); #1;
        if (!hold) cpu_access = 1'b0;
        cpu_data_out = ~wd;
        n = 0;
        while (mem_req === 1'b1 && n < 40) begin
            check("addr", {16'd0, mem_addr}, {16'd0, a});
            check("we", {31'd0, mem_we}, {31'd0, we});
            check("wdata", {24'd0, mem_wdata}, {24'd0, wd});
            check("req_ready", {31'd0, cpu_ready}, 0);
            if (n == ack_at) begin mem_ack = 1'b1; mem_rdata = rd; end
            if (n == clr_at) timeout_clear = 1'b1;
            @(posedge clk); #1;
            mem_ack = 1'b0;
            timeout_clear = 1'b0;
            n++;
        end
        check("req_len", n, exp_len);
        check("latency", cyc - t0, exp_len + 1);
        #1 check("done_ready", {31'd0, cpu_ready}, 1);
        done_cyc = cyc;
        if (sb.size() == 0) check("sb_empty", 1, 0);
        else begin
            e = sb.pop_front();
            check("rdata", {24'd0, cpu_data_in}, {24'd0, e.data});
            check("timeout", {31'd0, bus_timeout}, {31'd0, e.to});
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", {31'd0, mem_req}, 0);
        check("rst_data", {24'd0, cpu_data_in}, 0);
        check("rst_to", {31'd0, bus_timeout}, 0);
        check("rst_addr", {16'd0, mem_addr}, 0);
        check("rst_we", {31'd0, mem_we}, 0);
        check("rst_wdata", {24'd0, mem_wdata}, 0);
        check("rst_ready", {31'd0, cpu_ready}, 1);
        nrst = 1'b1;
        @(posedge clk); #1;

        run_txn(1'b0, 16'h12AB, 8'h00, 0, 8'h5C, 1'b0, -1, d1);
        run_txn(1'b1, 16'h0200, 8'h77, 4, 8'h33, 1'b0, -1, d1);
        run_txn(1'b0, 16'hBEEF, 8'h00, 99, 8'h44, 1'b0, -1, d1);

        repeat (3) @(posedge clk);
        #1 check("to_sticky", {31'd0, bus_timeout}, 1);
        timeout_clear = 1'b1;
        @(posedge clk); #1;
        timeout_clear = 1'b0;
        m_to = 1'b0;
        check("to_clear", {31'd0, bus_timeout}, 0);

        run_txn(1'b0, 16'h4321, 8'h00, 14, 8'hA5, 1'b0, -1, d1);
        mem_ack = 1'b1;
        mem_rdata = 8'h99;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        check("stray_req", {31'd0, mem_req}, 0);
        check("stray_data", {24'd0, cpu_data_in}, {24'd0, m_data});
        check("stray_ready", {31'd0, cpu_ready}, 1);

        run_txn(1'b0, 16'h1000, 8'h00, 0, 8'h11, 1'b1, -1, d1);
        run_txn(1'b1, 16'h1001, 8'h22, 0, 8'h00, 1'b1, -1, d2);
        run_txn(1'b0, 16'h1002, 8'h00, 0, 8'h33, 1'b0, -1, d3);
        check("b2b_period1", d2 - d1, 3);
        check("b2b_period2", d3 - d2, 3);

        run_txn(1'b1, 16'hFFFF, 8'h5A, 99, 8'h00, 1'b0, -1, d1);
        run_txn(1'b0, 16'h0001, 8'h00, 99, 8'h00, 1'b0, 14, d1);
        run_txn(1'b0, 16'h0002, 8'h00, 2, 8'hC3, 1'b0, 0, d1);
        run_txn(1'b0, 16'h0003, 8'h00, 99, 8'h00, 1'b0, -1, d1);

        cpu_access = 1'b1;
        cpu_write = 1'b0;
        cpu_addr_high = 8'h34;
        cpu_addr_low = 8'h56;
        @(posedge clk); #1;
        cpu_access = 1'b0;
        check("mid_req", {31'd0, mem_req}, 1);
        #2 nrst = 1'b0;
        #1;
        check("async_req", {31'd0, mem_req}, 0);
        check("async_data", {24'd0, cpu_data_in}, 0);
        check("async_to", {31'd0, bus_timeout}, 0);
        @(posedge clk); #1;
        mem_ack = 1'b1;
        mem_rdata = 8'h77;
        nrst = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        m_data = 8'h00;
        m_to = 1'b0;
        sb.delete();
        check("late_ack_req", {31'd0, mem_req}, 0);
        check("late_ack_data", {24'd0, cpu_data_in}, 0);
        check("post_rst_ready", {31'd0, cpu_ready}, 1);

        run_txn(1'b0, 16'h8001, 8'h00, 1, 8'h6E, 1'b0, -1, d1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
